// File: rtl/if_id_stage_if.sv
// Handshake and data bundle between the fetch/IF-ID stage and its surroundings:
// decode control, hazard unit, instruction memory and the decode stage.
interface if_id_stage_if;
  logic [1:0]  PC_src;
  logic [31:0] branch_target;
  logic [31:0] jr_target;
  logic        stall;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] IF_pc;
  logic [31:0] ID_instruction;
  logic [31:0] ID_pc_plus4;
  logic        ID_valid;

  modport slave (
    input  PC_src,
    input  branch_target,
    input  jr_target,
    input  stall,
    input  imem_data,
    output imem_addr,
    output IF_pc,
    output ID_instruction,
    output ID_pc_plus4,
    output ID_valid
  );

  modport master (
    output PC_src,
    output branch_target,
    output jr_target,
    output stall,
    output imem_data,
    input  imem_addr,
    input  IF_pc,
    input  ID_instruction,
    input  ID_pc_plus4,
    input  ID_valid
  );
endinterface

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline latch: PC register, next-PC selection,
// stall/flush priority and the registered instruction handed to decode.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  if_id_stage_if.slave  bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pp4_q, pp4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] jump_target_s;
  logic [31:0] next_pc_s;
  logic        redirect_s;

  assign pc_plus4_s    = pc_q + 32'd4;
  assign jump_target_s = {pp4_q[31:28], instr_q[25:0], 2'b00};
  assign redirect_s    = (bus.PC_src != 2'b00);

  // Next-PC selection from the decode controller's source code
  always_comb begin
    next_pc_s = pc_plus4_s;
    case (bus.PC_src)
      2'b00:   next_pc_s = pc_plus4_s;
      2'b01:   next_pc_s = bus.branch_target;
      2'b10:   next_pc_s = jump_target_s;
      2'b11:   next_pc_s = bus.jr_target;
      default: next_pc_s = pc_plus4_s;
    endcase
  end

  // Next state: a taken branch beats stall (it is older); stall beats j/jr
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pp4_d   = pp4_q;
    valid_d = valid_q;
    if (bus.PC_src == 2'b01) begin
      pc_d    = bus.branch_target;
      instr_d = NOP_WORD;
      pp4_d   = 32'h0000_0000;
      valid_d = 1'b0;
    end else if (bus.stall) begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pp4_d   = pp4_q;
      valid_d = valid_q;
    end else if (redirect_s) begin
      pc_d    = next_pc_s;
      instr_d = NOP_WORD;
      pp4_d   = 32'h0000_0000;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus4_s;
      instr_d = bus.imem_data;
      pp4_d   = pc_plus4_s;
      valid_d = 1'b1;
    end
  end

  // PC and IF/ID latch registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pp4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pp4_q   <= pp4_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.IF_pc          = pc_q;
  assign bus.ID_instruction = instr_q;
  assign bus.ID_pc_plus4    = pp4_q;
  assign bus.ID_valid       = valid_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: stimulus pushes the reference model's
// expected state, a monitor pops and compares after every clock edge.
module tb_if_id_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        valid;
  } st_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  st_t  model;
  st_t  sb_q[$];

  if_id_stage_if bus ();

  if_id_stage #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: word i holds 0x1000_0000+i, plus one planted j 0x100
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0040_000C) return 32'h0800_0100;
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  assign bus.imem_data = mem_word(bus.imem_addr);

  // Reference model: one clock edge of the fetch/IF-ID rules
  function automatic st_t model_next(input st_t s, input logic rst, input logic [1:0] src,
                                     input logic [31:0] bt, input logic [31:0] jt,
                                     input logic stl);
    st_t n;
    st_t bub;
    logic [31:0] p4;
    p4 = s.pc + 32'd4;
    bub = '{pc: 32'd0, instr: NOP, pp4: 32'd0, valid: 1'b0};
    if (rst) begin
      n = bub;
      n.pc = RST_PC;
    end else if (src == 2'b01) begin
      n = bub;
      n.pc = bt;
    end else if (stl) begin
      n = s;
    end else if (src == 2'b10) begin
      n = bub;
      n.pc = {s.pp4[31:28], s.instr[25:0], 2'b00};
    end else if (src == 2'b11) begin
      n = bub;
      n.pc = jt;
    end else begin
      n = '{pc: p4, instr: mem_word(s.pc), pp4: p4, valid: 1'b1};
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] src, input logic [31:0] bt,
                      input logic [31:0] jt, input logic stl);
    @(negedge clk);
    reset             = rst;
    bus.PC_src        = src;
    bus.branch_target = bt;
    bus.jr_target     = jt;
    bus.stall         = stl;
    model = model_next(model, rst, src, bt, jt, stl);
    sb_q.push_back(model);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge that had stimulus is compared against the scoreboard
  initial begin
    st_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_IF_pc", bus.IF_pc, e.pc);
        chk("sb_imem_addr", bus.imem_addr, e.pc);
        chk("sb_ID_instruction", bus.ID_instruction, e.instr);
        chk("sb_ID_pc_plus4", bus.ID_pc_plus4, e.pp4);
        chk("sb_ID_valid", {31'd0, bus.ID_valid}, {31'd0, e.valid});
      end
    end
  end

  initial begin
    logic [1:0] src;
    int r;
    model = '{pc: RST_PC, instr: NOP, pp4: 32'd0, valid: 1'b0};
    bus.PC_src = 2'b00;
    bus.branch_target = 32'd0;
    bus.jr_target = 32'd0;
    bus.stall = 1'b0;

    // Reset then free run
    step(1'b1, 2'b00, 32'd0, 32'd0, 1'b0);
    step(1'b1, 2'b00, 32'd0, 32'd0, 1'b0);
    after_edge();
    chk("rst_IF_pc", bus.IF_pc, 32'h0);
    chk("rst_valid", {31'd0, bus.ID_valid}, 32'd0);
    chk("rst_instr", bus.ID_instruction, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
      after_edge();
      chk("run_instr", bus.ID_instruction, 32'h1000_0000 + i);
      chk("run_pp4", bus.ID_pc_plus4, 32'd4 * (i + 1));
      chk("run_valid", {31'd0, bus.ID_valid}, 32'd1);
    end

    // j with ID_pc_plus4=0x0040_0010, field 0x100
    step(1'b0, 2'b01, 32'h0040_000C, 32'd0, 1'b0);
    step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    after_edge();
    chk("j_pp4", bus.ID_pc_plus4, 32'h0040_0010);
    step(1'b0, 2'b10, 32'd0, 32'd0, 1'b0);
    after_edge();
    chk("j_pc", bus.IF_pc, 32'h0000_0400);
    chk("j_bubble_valid", {31'd0, bus.ID_valid}, 32'd0);
    chk("j_bubble_instr", bus.ID_instruction, 32'h0);
    step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    after_edge();
    chk("j_target_instr", bus.ID_instruction, 32'h1000_0100);

    // Three-cycle stall at 0x20
    step(1'b0, 2'b01, 32'h0000_0020, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b00, 32'd0, 32'd0, 1'b1);
      after_edge();
      chk("stall_pc", bus.IF_pc, 32'h20);
      chk("stall_instr", bus.ID_instruction, 32'h0);
      chk("stall_pp4", bus.ID_pc_plus4, 32'h0);
    end
    step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    after_edge();
    chk("resume_pc", bus.IF_pc, 32'h24);
    chk("resume_instr", bus.ID_instruction, 32'h1000_0008);

    // Branch overrides stall; jr does not
    step(1'b0, 2'b01, 32'h0000_0080, 32'd0, 1'b1);
    after_edge();
    chk("br_stall_pc", bus.IF_pc, 32'h80);
    chk("br_stall_valid", {31'd0, bus.ID_valid}, 32'd0);
    step(1'b0, 2'b11, 32'd0, 32'h0000_0200, 1'b1);
    after_edge();
    chk("jr_stall_pc", bus.IF_pc, 32'h80);

    // Wrap-around of PC+4
    step(1'b0, 2'b01, 32'hFFFF_FFFC, 32'd0, 1'b0);
    step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    after_edge();
    chk("wrap_pc", bus.IF_pc, 32'h0);
    chk("wrap_pp4", bus.ID_pc_plus4, 32'h0);
    chk("wrap_valid", {31'd0, bus.ID_valid}, 32'd1);

    // Reset during a stall following a jr
    step(1'b0, 2'b11, 32'd0, 32'h0000_0100, 1'b0);
    step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    step(1'b0, 2'b11, 32'd0, 32'h0000_0300, 1'b1);
    after_edge();
    chk("jr_hold_pc", bus.IF_pc, 32'h104);
    step(1'b1, 2'b11, 32'd0, 32'h0000_0300, 1'b1);
    after_edge();
    chk("mid_rst_pc", bus.IF_pc, RST_PC);
    chk("mid_rst_valid", {31'd0, bus.ID_valid}, 32'd0);
    step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    after_edge();
    chk("post_rst_pc", bus.IF_pc, RST_PC + 32'd4);
    chk("post_rst_instr", bus.ID_instruction, mem_word(RST_PC));

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      src = (r < 6) ? 2'b00 : (r == 6) ? 2'b01 : (r == 7) ? 2'b10 : 2'b11;
      step(($urandom_range(0, 99) < 3), src, {20'd0, 10'($urandom_range(0, 1023)), 2'b00},
           {18'd0, 12'($urandom_range(0, 4095)), 2'b00}, ($urandom_range(0, 3) == 0));
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
    #3;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
